// File: rtl/bram_uart_readback.sv
// bram_uart_readback
// Reads `length` bytes from address 0 upward through a synchronous BRAM read
// port. Each byte is optionally XORed with the shared key and sent as UART 8N1,
// LSB first. `done` pulses once the last stop bit has been sent.
//
// state | meaning
// IDLE  | line high, waiting for start
// FETCH | rd_en high, BRAM address presented
// LOAD  | capture rd_data into the shift register, bump address and count
// START | start bit (tx=0) for one bit time
// DATA  | eight data bits, LSB first, one bit time each
// STOP  | stop bit (tx=1); then next byte or finish
// FIN   | one-cycle done pulse

module bram_uart_readback #(
   parameter int          CLK_FREQ     = 50000000,
   parameter int          BAUD_RATE    = 115200,
   parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
   parameter int          ADDR_W       = 14,
   parameter logic [7:0]  XOR_KEY      = 8'hAA,
   parameter bit          DECRYPT      = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] START = 3'd3;
   localparam logic [2:0] DATA  = 3'd4;
   localparam logic [2:0] STOP  = 3'd5;
   localparam logic [2:0] FIN   = 3'd6;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        shreg;
   logic [TW-1:0]     timer;
   logic [2:0]        bit_idx;

   // Status outputs decode straight from the state register.
   assign rd_en   = (state == FETCH);
   assign rd_addr = addr;
   assign busy    = (state != IDLE) && (state != FIN);
   assign done    = (state == FIN);

   // Sequencer, bit timer and registered serial line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         shreg     <= '0;
         timer     <= '0;
         bit_idx   <= '0;
         tx        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (start) begin
                  if (length != '0) begin
                     remaining <= length;
                     addr      <= '0;
                     state     <= FETCH;
                  end else begin
                     state <= FIN;
                  end
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               shreg     <= DECRYPT ? (rd_data ^ XOR_KEY) : rd_data;
               // wraps to 0 after a full-depth dump, which is harmless
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
               timer     <= BIT_LAST;
               tx        <= 1'b0;
               state     <= START;
            end
            START: begin
               if (timer == '0) begin
                  timer   <= BIT_LAST;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            DATA: begin
               if (timer == '0) begin
                  timer <= BIT_LAST;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            STOP: begin
               if (timer == '0) begin
                  state <= (remaining != '0) ? FETCH : FIN;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_uart_readback.sv
// Bench for bram_uart_readback: two instances at 10 clocks per bit, one
// decrypting (8-bit address), one raw (3-bit address, for the wrap case).
// Expected bytes and addresses are queued at request time; monitors decode
// the serial line and watch the read port and pop/compare independently.
module tb_bram_uart_readback;

   localparam int CPB   = 10;
   localparam int FRAME = 10 * CPB + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start_a = 1'b0, start_b = 1'b0;
   logic [8:0] len_a = '0;
   logic [3:0] len_b = '0;
   logic       rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
   logic [7:0] rd_addr_a;
   logic [2:0] rd_addr_b;
   logic [7:0] rd_data_a = '0, rd_data_b = '0;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [8];

   bram_uart_readback #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .ADDR_W(8),
                        .XOR_KEY(8'hAA), .DECRYPT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .length(len_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .tx(tx_a), .busy(busy_a), .done(done_a));

   bram_uart_readback #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .ADDR_W(3),
                        .XOR_KEY(8'hAA), .DECRYPT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .length(len_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .tx(tx_b), .busy(busy_b), .done(done_b));

   // 1-cycle latency BRAM models
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
   end

   logic       tx_w [2];
   logic       rd_en_w [2];
   logic       done_w [2];
   logic [7:0] addr_w [2];
   assign tx_w[0] = tx_a;        assign tx_w[1] = tx_b;
   assign rd_en_w[0] = rd_en_a;  assign rd_en_w[1] = rd_en_b;
   assign done_w[0] = done_a;    assign done_w[1] = done_b;
   assign addr_w[0] = rd_addr_a; assign addr_w[1] = {5'd0, rd_addr_b};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q [2][$];
   int         addr_q [2][$];
   int         done_cnt [2];
   int         burst_start [2];
   bit         ignore [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input int act);
      vectors++;
      miscompares++;
      $display("FAIL %s: observed %0d, expected none (cycle %0d)", name, act, cyc);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      // serial line decoder: sample at bit centres, compare against the model
      initial begin
         int prev;
         logic [7:0] b;
         logic stop;
         prev = -100000;
         forever begin
            @(negedge clk);
            if (tx_w[g] === 1'b0) begin
               if (!ignore[g]) begin
                  if (prev > burst_start[g]) check("frame_period", cyc - prev, FRAME);
                  else check("first_fall_latency", cyc - burst_start[g], 3);
               end
               prev = cyc;
               repeat (CPB / 2) @(negedge clk);
               if (!ignore[g]) check("start_bit", tx_w[g], 1'b0);
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  b[i] = tx_w[g];
               end
               repeat (CPB) @(negedge clk);
               stop = tx_w[g];
               if (!ignore[g]) begin
                  check("stop_bit", stop, 1'b1);
                  if (exp_q[g].size() == 0) flag("unexpected_byte", b);
                  else check("rx_byte", b, exp_q[g].pop_front());
               end
            end
         end
      end

      // read-port monitor and done counter
      always @(negedge clk) begin
         if (rd_en_w[g]) begin
            if (addr_q[g].size() == 0) flag("extra_rd_en", addr_w[g]);
            else check("rd_addr", addr_w[g], addr_q[g].pop_front());
         end
         if (done_w[g]) done_cnt[g] <= done_cnt[g] + 1;
      end
   end

   // Reference model: byte i of a dump is mem[i mod depth], XORed when decrypting.
   task automatic issue(input int g, input int len, input bit push_bytes);
      @(negedge clk);
      burst_start[g] = cyc;
      for (int i = 0; i < len; i++) begin
         if (g == 0) begin
            addr_q[0].push_back(i % 256);
            if (push_bytes) exp_q[0].push_back(mem_a[i % 256] ^ 8'hAA);
         end else begin
            addr_q[1].push_back(i % 8);
            if (push_bytes) exp_q[1].push_back(mem_b[i % 8]);
         end
      end
      if (g == 0) begin len_a = 9'(len); start_a = 1'b1; end
      else begin len_b = 4'(len); start_b = 1'b1; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      check("busy_after_start", (g == 0) ? busy_a : busy_b, len != 0);
   endtask

   task automatic wait_done(input int g, input int len, input int n0);
      int n;
      int lim;
      n = n0;
      lim = len * FRAME + 30;
      while (done_w[g] !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (done_w[g] !== 1'b1) begin
         flag("done_timeout", n);
      end else begin
         vectors++;
         if (len == 0 ? (n != 1) : (n < len * FRAME - 1 || n > len * FRAME + 1)) begin
            miscompares++;
            $display("FAIL done_latency: got %0d cycles, expected %0d +/-1", n, len * FRAME);
         end
         check("tx_high_at_done", tx_w[g], 1'b1);
      end
      repeat (3) @(negedge clk);
      check("bytes_outstanding", exp_q[g].size(), 0);
      check("reads_outstanding", addr_q[g].size(), 0);
   endtask

   initial begin
      int len;
      int d0;
      done_cnt[0] = 0; done_cnt[1] = 0;
      burst_start[0] = 0; burst_start[1] = 0;
      ignore[0] = 1'b0; ignore[1] = 1'b0;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem_b[i] = 8'h00;

      // reset while idle
      repeat (3) @(negedge clk);
      check("rst_tx_a", tx_a, 1'b1);
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_rd_en_a", rd_en_a, 1'b0);
      check("rst_tx_b", tx_b, 1'b1);
      check("rst_done_b", done_b, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // single byte 6B -> C1
      mem_a[0] = 8'h6B;
      issue(0, 1, 1'b1);
      wait_done(0, 1, 1);

      // burst of four, decrypted and raw
      mem_a[0] = 8'hAA; mem_a[1] = 8'h00; mem_a[2] = 8'hFF; mem_a[3] = 8'h55;
      mem_b[0] = 8'hAA; mem_b[1] = 8'h00; mem_b[2] = 8'hFF; mem_b[3] = 8'h55;
      issue(0, 4, 1'b1);
      wait_done(0, 4, 1);
      issue(1, 4, 1'b1);
      wait_done(1, 4, 1);

      // length 0: done next cycle, nothing on the line
      d0 = done_cnt[0];
      issue(0, 0, 1'b1);
      wait_done(0, 0, 1);
      check("len0_done_count", done_cnt[0] - d0, 1);

      // second start mid-burst is ignored
      for (int i = 0; i < 3; i++) mem_a[i] = 8'($urandom);
      issue(0, 3, 1'b1);
      repeat (150) @(negedge clk);
      len_a = 9'd5;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      wait_done(0, 3, 153);

      // randomized dumps
      for (int k = 0; k < 6; k++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) mem_a[i] = 8'($urandom);
         issue(0, len, 1'b1);
         wait_done(0, len, 1);
      end

      // full-depth dump on the 3-bit address instance wraps the address
      for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
      d0 = done_cnt[1];
      issue(1, 8, 1'b1);
      wait_done(1, 8, 1);
      check("wrap_final_addr", rd_addr_b, 3'd0);
      check("wrap_done_count", done_cnt[1] - d0, 1);

      // reset in the middle of a data bit of an all-zero byte
      mem_b[0] = 8'h00;
      ignore[1] = 1'b1;
      d0 = done_cnt[1];
      issue(1, 1, 1'b0);
      repeat (19) @(negedge clk);
      check("tx_low_before_rst", tx_b, 1'b0);
      rst = 1'b1;
      #1;
      check("tx_async_rst", tx_b, 1'b1);
      check("busy_async_rst", busy_b, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("no_done_after_rst", done_cnt[1] - d0, 0);
      check("idle_tx_after_rst", tx_b, 1'b1);
      check("idle_busy_after_rst", busy_b, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/bram_uart_readback.md
# bram_uart_readback

Reads a run of bytes from the encryption BRAM through a synchronous read port, optionally XOR-decrypts them with the shared key, and serialises each byte onto a UART TX line as 8N1, LSB first. It is the return path of the UART-in / XOR-encrypt / BRAM store chain and drives the PC's RX pin. One start pulse dumps `length` bytes from address 0 upward, then reports `done`.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: UART line rate.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD_RATE (integer division; 434 at defaults): clocks per serial bit.
- `ADDR_W`, 14: BRAM address width (16384 bytes).
- `XOR_KEY`, 8'hAA: key, identical to the write-side key.
- `DECRYPT`, 1: 1 = transmit `rd_data ^ XOR_KEY`; 0 = transmit raw stored byte.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a dump; sampled only in IDLE.
- `length`, in, ADDR_W+1: number of bytes to send, 0..2^ADDR_W; sampled with `start`.
- `rd_en`, out, 1: BRAM read strobe.
- `rd_addr`, out, ADDR_W: BRAM read address.
- `rd_data`, in, 8: BRAM read data, valid exactly one cycle after `rd_en`.
- `tx`, out, 1: serial output, idle high.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP, FIN.
- IDLE: `tx`=1. On `start`=1 with `length`≠0: latch `length` into the remaining counter, clear the address, go to FETCH. On `start` with `length`=0: go to FIN directly. No `rd_en` and no line activity in that case.
- FETCH: `rd_en`=1 for one cycle, with `rd_addr` = current address. Go to LOAD.
- LOAD: capture `rd_data` (XORed if DECRYPT=1) into the shift register. Increment the address, decrement the remaining counter. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then go to FETCH if remaining ≠ 0, else go to FIN.
- FIN: `done`=1 for one cycle, `busy` drops. Return to IDLE.
- `start` asserted while not in IDLE is ignored and is not queued.
- The address is ADDR_W bits wide. `length` = 2^ADDR_W reads addresses 0..2^ADDR_W−1, and the address wraps to 0 after the last read; that wrap is harmless.
- The bit timer counts CLKS_PER_BIT−1 down to 0. Its width is $clog2(CLKS_PER_BIT).
- `tx` is driven from a register, never from combinational logic.

## Timing
- Reset values: `tx`=1, `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame: `tx` returns high asynchronously, and the partial byte is abandoned. After release the block stays in IDLE until a new `start`.
- `start` in cycle T: FETCH in T+1 (`rd_en`=1), LOAD in T+2, `tx` falls at the edge ending T+2. `busy`=1 from T+1.
- Frame: 10×CLKS_PER_BIT cycles (start + 8 data + stop).
- Inter-byte gap: exactly 2 cycles of `tx`=1 (FETCH + LOAD) after each stop bit, in addition to the stop bit itself.
- Total dump time for N≥1 bytes: N×(10×CLKS_PER_BIT + 2) cycles from `start` to `done`, ±1 cycle at the ends. `done` is asserted in the cycle after the last stop bit ends.
- `length`=0: `done` asserted in T+1, `busy` stays 0.
- Exactly one `rd_en` per byte, and never more than N per dump.

## Test plan
Bench uses CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10) and a behavioural 1-cycle-latency BRAM model.

- Reset while idle: check `tx`=1, `busy`=0, `done`=0. Then apply `rst` in the middle of a data bit: `tx` goes to 1 in the same cycle, and there is no `done` after release.
- Single byte: preload mem[0]=8'h6B, DECRYPT=1, `start` with `length`=1. The line decodes 8'hC1; exactly 102 cycles (±1) elapse to `done`; one `rd_en` is seen at `rd_addr`=0.
- Burst of 4 bytes: mem[0..3] = 8'hAA, 8'h00, 8'hFF, 8'h55. The decoded sequence is 8'h00, 8'hAA, 8'h55, 8'hFF. There is a 2-cycle high gap between frames, and `rd_addr` steps 0→3.
- DECRYPT=0 with the same preload: the raw bytes 8'hAA, 8'h00, 8'hFF, 8'h55 appear on the line.
- Edge requests: `length`=0 produces `done` in the next cycle with `tx` constantly high. A second `start` pulsed mid-burst is ignored, and the byte count stays at the original `length`.
- Wrap: ADDR_W=3, `length`=8 reads addresses 0..7, the final address register is 0, and `done` pulses once.
